elevator_dest_scheduler: RTL and testbench

//  Parametrised next-destination scheduler for one elevator car (N floors).
//  On a start pulse it snapshots the request queue and scans one floor per cycle,

---
 rtl/elevator_dest_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_elevator_dest_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/elevator_dest_scheduler.sv
// Next-destination scheduler for one elevator car.
// Snapshots the request queue on start, scans one floor per cycle ahead of the
// car in its travel direction, then behind it, and reports the nearest pending
// floor plus the direction to reach it through a start/done handshake.
// Optional feature macro: DEST_HOME_RETURN_EN (park at HOME_FLOOR when idle).
module elevator_dest_scheduler #(
  parameter int unsigned NUM_FLOORS = 7,
  parameter int unsigned HOME_FLOOR = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                up_ndown,
  input  logic [$clog2(NUM_FLOORS+1)-1:0]     current_floor,
  input  logic [NUM_FLOORS-1:0]               queue_status,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(NUM_FLOORS+1)-1:0]     destination_floor,
  output logic                                dest_dir_up,
  output logic                                no_request
);

  localparam int unsigned FLOOR_W = $clog2(NUM_FLOORS + 1);
  localparam int unsigned IDX_W   = FLOOR_W + 1;

  localparam logic [FLOOR_W-1:0] NONE     = '1;
  localparam logic [IDX_W-1:0]   ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0]   TOP      = IDX_W'(NUM_FLOORS - 1);
  localparam logic [IDX_W-1:0]   N_FLOORS = IDX_W'(NUM_FLOORS);

  // Elaboration-time sanity check of the configuration.
  if (NUM_FLOORS < 2 || HOME_FLOOR >= NUM_FLOORS) begin : g_bad_cfg
    $error("elevator_dest_scheduler: NUM_FLOORS must be >= 2 and HOME_FLOOR < NUM_FLOORS");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_AHEAD,
    S_BEHIND,
    S_FINISH
  } state_t;

  state_t               state, state_nxt;
  logic [FLOOR_W-1:0]   snap_floor, snap_floor_nxt;
  logic                 snap_dir, snap_dir_nxt;
  logic [NUM_FLOORS-1:0] snap_queue, snap_queue_nxt;
  logic [IDX_W-1:0]     scan_idx, scan_idx_nxt;
  logic [FLOOR_W-1:0]   res_floor, res_floor_nxt;
  logic                 res_dir, res_dir_nxt;
  logic                 res_none, res_none_nxt;
  logic                 busy_nxt, done_nxt, dir_nxt, no_req_nxt;
  logic [FLOOR_W-1:0]   dest_nxt;
  logic [FLOOR_W-1:0]   miss_floor;
  logic                 miss_dir;

  // Pending-request bit at an index; shift avoids an oversized index select.
  function automatic logic queue_bit(input logic [NUM_FLOORS-1:0] q,
                                     input logic [IDX_W-1:0] i);
    logic [NUM_FLOORS-1:0] shifted;
    shifted = q >> i;
    return shifted[0];
  endfunction

  // Result reported when a valid snapshot held no request.
`ifdef DEST_HOME_RETURN_EN
  localparam logic [FLOOR_W-1:0] HOME = FLOOR_W'(HOME_FLOOR);
  assign miss_floor = HOME;
  assign miss_dir   = (HOME > snap_floor) ? 1'b1 :
                      (HOME == snap_floor) ? snap_dir : 1'b0;
`else
  assign miss_floor = NONE;
  assign miss_dir   = snap_dir;
`endif

  // Next-state, scan walk and output update.
  always_comb begin
    state_nxt      = state;
    snap_floor_nxt = snap_floor;
    snap_dir_nxt   = snap_dir;
    snap_queue_nxt = snap_queue;
    scan_idx_nxt   = scan_idx;
    res_floor_nxt  = res_floor;
    res_dir_nxt    = res_dir;
    res_none_nxt   = res_none;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    dest_nxt       = destination_floor;
    dir_nxt        = dest_dir_up;
    no_req_nxt     = no_request;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          snap_floor_nxt = current_floor;
          snap_dir_nxt   = up_ndown;
          snap_queue_nxt = queue_status;
          busy_nxt       = 1'b1;
          if (IDX_W'(current_floor) >= N_FLOORS) begin
            state_nxt     = S_FINISH;
            res_floor_nxt = NONE;
            res_dir_nxt   = up_ndown;
            res_none_nxt  = 1'b1;
          end else if (queue_bit(queue_status, IDX_W'(current_floor))) begin
            state_nxt     = S_FINISH;
            res_floor_nxt = current_floor;
            res_dir_nxt   = up_ndown;
            res_none_nxt  = 1'b0;
          end else if (up_ndown && (IDX_W'(current_floor) == TOP)) begin
            state_nxt    = S_BEHIND;
            scan_idx_nxt = IDX_W'(current_floor) - ONE;
          end else if (!up_ndown && (current_floor == '0)) begin
            state_nxt    = S_BEHIND;
            scan_idx_nxt = IDX_W'(current_floor) + ONE;
          end else begin
            state_nxt    = S_AHEAD;
            scan_idx_nxt = up_ndown ? (IDX_W'(current_floor) + ONE)
                                    : (IDX_W'(current_floor) - ONE);
          end
        end
      end

      S_AHEAD: begin
        if (queue_bit(snap_queue, scan_idx)) begin
          state_nxt     = S_FINISH;
          res_floor_nxt = scan_idx[FLOOR_W-1:0];
          res_dir_nxt   = snap_dir;
          res_none_nxt  = 1'b0;
        end else if (snap_dir ? (scan_idx == TOP) : (scan_idx == '0)) begin
          // Car parked at the far edge has nothing behind it.
          if (snap_dir ? (snap_floor == '0) : (IDX_W'(snap_floor) == TOP)) begin
            state_nxt     = S_FINISH;
            res_floor_nxt = miss_floor;
            res_dir_nxt   = miss_dir;
            res_none_nxt  = 1'b1;
          end else begin
            state_nxt    = S_BEHIND;
            scan_idx_nxt = snap_dir ? (IDX_W'(snap_floor) - ONE)
                                    : (IDX_W'(snap_floor) + ONE);
          end
        end else begin
          scan_idx_nxt = snap_dir ? (scan_idx + ONE) : (scan_idx - ONE);
        end
      end

      S_BEHIND: begin
        if (queue_bit(snap_queue, scan_idx)) begin
          state_nxt     = S_FINISH;
          res_floor_nxt = scan_idx[FLOOR_W-1:0];
          res_dir_nxt   = !snap_dir;
          res_none_nxt  = 1'b0;
        end else if (snap_dir ? (scan_idx == '0) : (scan_idx == TOP)) begin
          state_nxt     = S_FINISH;
          res_floor_nxt = miss_floor;
          res_dir_nxt   = miss_dir;
          res_none_nxt  = 1'b1;
        end else begin
          scan_idx_nxt = snap_dir ? (scan_idx - ONE) : (scan_idx + ONE);
        end
      end

      S_FINISH: begin
        state_nxt  = S_IDLE;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b1;
        dest_nxt   = res_floor;
        dir_nxt    = res_dir;
        no_req_nxt = res_none;
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, snapshot and registered outputs; reset aborts any scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      snap_floor        <= '0;
      snap_dir          <= 1'b0;
      snap_queue        <= '0;
      scan_idx          <= '0;
      res_floor         <= NONE;
      res_dir           <= 1'b1;
      res_none          <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      destination_floor <= NONE;
      dest_dir_up       <= 1'b1;
      no_request        <= 1'b1;
    end else begin
      state             <= state_nxt;
      snap_floor        <= snap_floor_nxt;
      snap_dir          <= snap_dir_nxt;
      snap_queue        <= snap_queue_nxt;
      scan_idx          <= scan_idx_nxt;
      res_floor         <= res_floor_nxt;
      res_dir           <= res_dir_nxt;
      res_none          <= res_none_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      destination_floor <= dest_nxt;
      dest_dir_up       <= dir_nxt;
      no_request        <= no_req_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_dest_scheduler.sv
// Directed self-checking bench for elevator_dest_scheduler (7 floors, home 0).
module tb_elevator_dest_scheduler;

  localparam int unsigned NF = 7;
  localparam int unsigned FW = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic          up_ndown;
  logic [FW-1:0] current_floor;
  logic [NF-1:0] queue_status;
  logic          busy;
  logic          done;
  logic [FW-1:0] destination_floor;
  logic          dest_dir_up;
  logic          no_request;

  int n_cmp  = 0;
  int n_fail = 0;

  elevator_dest_scheduler #(.NUM_FLOORS(NF), .HOME_FLOOR(0)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .up_ndown          (up_ndown),
    .current_floor     (current_floor),
    .queue_status      (queue_status),
    .busy              (busy),
    .done              (done),
    .destination_floor (destination_floor),
    .dest_dir_up       (dest_dir_up),
    .no_request        (no_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a scan request for one clock edge; returns 1ns after the accepting edge.
  task automatic launch(input logic [FW-1:0] f, input logic d, input logic [NF-1:0] q);
    current_floor = f;
    up_ndown      = d;
    queue_status  = q;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done rises; a value past the budget means timeout.
  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic scan(input string tag, input logic [FW-1:0] f, input logic d,
                      input logic [NF-1:0] q, input int exp_lat,
                      input logic [FW-1:0] exp_dest, input logic exp_dir,
                      input logic exp_nr);
    int lat;
    launch(f, d, q);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(0, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dest"}, 32'(destination_floor), 32'(exp_dest));
    check({tag, "_dir"}, 32'(dest_dir_up), 32'(exp_dir));
    check({tag, "_nr"}, 32'(no_request), 32'(exp_nr));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int extra;
    reset         = 1'b0;
    start         = 1'b0;
    up_ndown      = 1'b0;
    current_floor = '0;
    queue_status  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dest", 32'(destination_floor), 32'd7);
    check("rst_dir", 32'(dest_dir_up), 32'd1);
    check("rst_nr", 32'(no_request), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Examples with hand-derived latency 1+k.
    scan("up_ahead", 3'd2, 1'b1, 7'b0010000, 3, 3'd4, 1'b1, 1'b0);
    scan("up_reverse", 3'd5, 1'b1, 7'b0000010, 6, 3'd1, 1'b0, 1'b0);
    scan("cur_hit", 3'd3, 1'b0, 7'b0001000, 1, 3'd3, 1'b0, 1'b0);
`ifdef DEST_HOME_RETURN_EN
    scan("top_empty", 3'd6, 1'b1, 7'b0000000, 7, 3'd0, 1'b0, 1'b1);
    scan("bot_empty", 3'd0, 1'b1, 7'b0000000, 7, 3'd0, 1'b1, 1'b1);
`else
    scan("top_empty", 3'd6, 1'b1, 7'b0000000, 7, 3'd7, 1'b1, 1'b1);
    scan("bot_empty", 3'd0, 1'b1, 7'b0000000, 7, 3'd7, 1'b1, 1'b1);
`endif
    scan("down_reverse", 3'd3, 1'b0, 7'b0100000, 6, 3'd5, 1'b1, 1'b0);
    scan("ahead_first", 3'd3, 1'b1, 7'b1000010, 4, 3'd6, 1'b1, 1'b0);
    scan("bot_down_edge", 3'd0, 1'b0, 7'b1000000, 7, 3'd6, 1'b1, 1'b0);

    // Invalid floor: immediate NONE regardless of queue.
    launch(3'd7, 1'b1, 7'b1111111);
    wait_done(0, lat);
    check("inv_lat", 32'(lat), 32'd1);
    check("inv_dest", 32'(destination_floor), 32'd7);
    check("inv_nr", 32'(no_request), 32'd1);
    @(posedge clk); #1;

    // Result registers hold while idle and inputs wander.
    current_floor = 3'd1;
    queue_status  = 7'b1111111;
    repeat (3) @(posedge clk);
    #1;
    check("hold_dest", 32'(destination_floor), 32'd7);
    check("hold_busy", 32'(busy), 32'd0);

    // Restart while busy is ignored; queue change after snapshot is ignored.
    launch(3'd2, 1'b1, 7'b0100000);
    start = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    queue_status = '0;
    wait_done(1, lat);
    check("snap_lat", 32'(lat), 32'd4);
    check("snap_dest", 32'(destination_floor), 32'd5);
    check("snap_nr", 32'(no_request), 32'd0);
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("snap_single_done", 32'(extra), 32'd0);

    // Reset mid-scan aborts without a done pulse.
    launch(3'd5, 1'b1, 7'b0000010);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dest", 32'(destination_floor), 32'd7);
    @(posedge clk); #1;
    reset = 1'b1;
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    scan("after_abort", 3'd1, 1'b0, 7'b0000001, 2, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
